// File: rtl/qpp_addr_gen.sv
// qpp_addr_gen
// QPP turbo-interleaver address generator. It follows the sequential index
// stream 0..K-1 and emits pi(i) = (f1*i + f2*i^2) mod K. There are no
// multipliers. The recursion used is:
//   pi(i+1) = pi(i) + g(i)
//   g(i+1)  = g(i) + 2*f2
// Both sums are taken mod K.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   k          in   block size select (0: K_SHORT, 1: K_LONG), sampled on start
//   start      in   one-cycle pulse that begins a new block (wins over idx_valid)
//   idx_valid  in   advance the recursion by one step
//   idx        in   incoming sequential index (only used by the sequence check)
//   addr       out  interleaved address, registered, one cycle after the step
//   addr_valid out  addr is valid this cycle
//   addr_last  out  asserted together with addr_valid for i = K-1
//   busy       out  block in progress (RUN)
//   seq_err    out  sticky index-discontinuity flag
//
// Optional feature macro: QPP_SEQ_CHECK_EN
//   When defined, each RUN step compares idx against the internal count.
//   A mismatch sets seq_err, which is cleared only by reset or by start.
//   When not defined, seq_err is tied to 0.
module qpp_addr_gen #(
  parameter int W       = 14,
  parameter int K_SHORT = 1056,
  parameter int F1_S    = 17,
  parameter int F2_S    = 66,
  parameter int K_LONG  = 6144,
  parameter int F1_L    = 263,
  parameter int F2_L    = 480
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         k,
  input  logic         start,
  input  logic         idx_valid,
  input  logic [W-1:0] idx,
  output logic [W-1:0] addr,
  output logic         addr_valid,
  output logic         addr_last,
  output logic         busy,
  output logic         seq_err
);

  // All recursion constants are reduced mod K at elaboration, so modadd
  // always sees operands that are already < K.
  localparam logic [W-1:0] KS      = W'(K_SHORT);
  localparam logic [W-1:0] KL      = W'(K_LONG);
  localparam logic [W-1:0] G0_S    = W'((F1_S + F2_S) % K_SHORT);
  localparam logic [W-1:0] G0_L    = W'((F1_L + F2_L) % K_LONG);
  localparam logic [W-1:0] GSTEP_S = W'((2 * F2_S) % K_SHORT);
  localparam logic [W-1:0] GSTEP_L = W'((2 * F2_L) % K_LONG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         k_q, k_d;
  logic [W-1:0] pi_q, pi_d;
  logic [W-1:0] g_q, g_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] addr_q, addr_d;
  logic         addr_valid_q, addr_valid_d;
  logic         addr_last_q, addr_last_d;
  logic         seq_err_q, seq_err_d;

  logic [W-1:0] k_len_s;
  logic [W-1:0] g_step_s;
  logic         last_s;

  // (a + b) mod K when a, b < K. One conditional subtract is enough because
  // the sum is below 2K, and it fits in W+1 bits.
  function automatic logic [W-1:0] modadd(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] kk);
    logic [W:0] s;
    logic [W:0] d;
    s = {1'b0, a} + {1'b0, b};
    d = s - {1'b0, kk};
    if (s >= {1'b0, kk}) begin
      modadd = d[W-1:0];
    end else begin
      modadd = s[W-1:0];
    end
  endfunction

  // Per-block constants selected by the k value latched at start.
  always_comb begin
    k_len_s  = KS;
    g_step_s = GSTEP_S;
    if (k_q) begin
      k_len_s  = KL;
      g_step_s = GSTEP_L;
    end else begin
      k_len_s  = KS;
      g_step_s = GSTEP_S;
    end
    last_s = (cnt_q == (k_len_s - {{(W-1){1'b0}}, 1'b1}));
  end

  // Next-state, recursion step and output register inputs.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    pi_d         = pi_q;
    g_d          = g_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    addr_valid_d = 1'b0;
    addr_last_d  = 1'b0;
    seq_err_d    = seq_err_q;
    if (start) begin
      // Restart from any state. A coincident idx is dropped.
      state_d   = S_RUN;
      k_d       = k;
      pi_d      = {W{1'b0}};
      cnt_d     = {W{1'b0}};
      g_d       = k ? G0_L : G0_S;
      seq_err_d = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (idx_valid) begin
            addr_d       = pi_q;
            addr_valid_d = 1'b1;
            addr_last_d  = last_s;
            pi_d         = modadd(pi_q, g_q, k_len_s);
            g_d          = modadd(g_q, g_step_s, k_len_s);
            cnt_d        = cnt_q + {{(W-1){1'b0}}, 1'b1};
`ifdef QPP_SEQ_CHECK_EN
            if (idx != cnt_q) begin
              seq_err_d = 1'b1;
            end else begin
              seq_err_d = seq_err_q;
            end
`endif
            if (last_s) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            // Stall: the recursion holds and addr keeps its last value.
            state_d = S_RUN;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      k_q          <= 1'b0;
      pi_q         <= {W{1'b0}};
      g_q          <= {W{1'b0}};
      cnt_q        <= {W{1'b0}};
      addr_q       <= {W{1'b0}};
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      pi_q         <= pi_d;
      g_q          <= g_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      addr_last_q  <= addr_last_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign addr_last  = addr_last_q;
  assign busy       = (state_q == S_RUN);
`ifdef QPP_SEQ_CHECK_EN
  assign seq_err    = seq_err_q;
`else
  assign seq_err    = 1'b0;
  // The sticky flag register and idx are only consumed by the checker.
  logic unused_s;
  assign unused_s   = seq_err_q ^ (^idx);
`endif

endmodule
